// File: rtl/scoot_bot_ctrl.sv
`default_nettype none
// ============================================================================
// scoot_bot_ctrl : grid-agent controller steering toward the strongest recent
//                  sensor direction, with pickup and wander behaviours.
// Revision 1.0
// ============================================================================
module scoot_bot_ctrl #(
  parameter int NUM_DIRS       = 4,
  parameter int HIST_DEPTH     = 3,
  parameter int WANDER_TIMEOUT = 8,
  parameter int PICK_CYCLES    = 2,
  parameter int TIE_ROTATE     = 0,
  parameter int CNT_W          = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_DIRS-1:0] sense,
  input  logic                here,
  output logic [NUM_DIRS-1:0] motor,
  output logic                pick,
  output logic [1:0]          state,
  output logic [CNT_W-1:0]    pick_count
);

  localparam int c_DIR_W   = (NUM_DIRS > 1) ? $clog2(NUM_DIRS) : 1;
  localparam int c_SCORE_W = $clog2(HIST_DEPTH + 1);
  localparam int c_IDLE_W  = $clog2(WANDER_TIMEOUT + 1);
  localparam int c_PICK_W  = $clog2(PICK_CYCLES + 1);

  localparam logic [c_DIR_W-1:0]  c_LAST_IDX   = c_DIR_W'(NUM_DIRS - 1);
  localparam logic [c_DIR_W:0]    c_NUM_DIRS_X = (c_DIR_W + 1)'(NUM_DIRS);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST  = c_IDLE_W'(WANDER_TIMEOUT - 1);
  localparam logic [c_PICK_W-1:0] c_PICK_LAST  = c_PICK_W'(PICK_CYCLES - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SEEK   = 2'd1;
  localparam logic [1:0] c_WANDER = 2'd2;
  localparam logic [1:0] c_PICK   = 2'd3;

  logic [1:0]            r_state;
  logic [HIST_DEPTH-1:0] r_hist [NUM_DIRS];
  logic [NUM_DIRS-1:0]   r_motor;
  logic                  r_pick;
  logic [CNT_W-1:0]      r_cnt;
  logic [c_IDLE_W-1:0]   r_idle_cnt;
  logic [c_PICK_W-1:0]   r_pick_tmr;
  logic [c_DIR_W-1:0]    r_wander_dir;
  logic [c_DIR_W-1:0]    r_last_dir;

  logic [HIST_DEPTH-1:0] w_hist_nxt [NUM_DIRS];
  logic [c_SCORE_W-1:0]  w_score    [NUM_DIRS];
  logic [c_DIR_W-1:0]    w_start;
  logic [c_DIR_W:0]      w_scan_idx;
  logic [c_DIR_W-1:0]    w_best;
  logic [c_SCORE_W-1:0]  w_best_score;
  logic                  w_any;
  logic [NUM_DIRS-1:0]   w_best_oh;
  logic [NUM_DIRS-1:0]   w_wander_oh;
  logic                  w_idle_hit;
  logic                  w_pick_done;

  logic [1:0]            w_state_nxt;
  logic [NUM_DIRS-1:0]   w_motor_nxt;
  logic                  w_pick_nxt;
  logic                  w_hist_clr;
  logic                  w_cnt_inc;
  logic [c_IDLE_W-1:0]   w_idle_cnt_nxt;
  logic [c_PICK_W-1:0]   w_pick_tmr_nxt;
  logic [c_DIR_W-1:0]    w_wander_dir_nxt;
  logic [c_DIR_W-1:0]    w_last_dir_nxt;

  function automatic logic [c_SCORE_W-1:0] f_popcount(input logic [HIST_DEPTH-1:0] v);
    logic [c_SCORE_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < HIST_DEPTH; i++) sum = sum + c_SCORE_W'(v[i]);
    return sum;
  endfunction

  // Scores are taken from the post-shift history so this edge's sense counts.
  generate
    for (genvar d = 0; d < NUM_DIRS; d++) begin : g_dir
      assign w_hist_nxt[d] = (r_hist[d] << 1) | HIST_DEPTH'(sense[d]);
      assign w_score[d]    = f_popcount(w_hist_nxt[d]);
    end
  endgenerate

  // Strict '>' keeps the first maximum met while scanning from w_start.
  always_comb begin : p_argmax
    w_start = '0;
    if (TIE_ROTATE != 0) w_start = (r_last_dir == c_LAST_IDX) ? '0 : r_last_dir + c_DIR_W'(1);
    w_best       = w_start;
    w_best_score = '0;
    w_scan_idx   = '0;
    for (int k = 0; k < NUM_DIRS; k++) begin
      w_scan_idx = {1'b0, w_start} + (c_DIR_W + 1)'(k);
      if (w_scan_idx >= c_NUM_DIRS_X) w_scan_idx = w_scan_idx - c_NUM_DIRS_X;
      if (w_score[w_scan_idx[c_DIR_W-1:0]] > w_best_score) begin
        w_best_score = w_score[w_scan_idx[c_DIR_W-1:0]];
        w_best       = w_scan_idx[c_DIR_W-1:0];
      end
    end
  end

  assign w_any       = (w_best_score != '0);
  assign w_best_oh   = NUM_DIRS'(1) << w_best;
  assign w_wander_oh = NUM_DIRS'(1) << r_wander_dir;
  assign w_idle_hit  = (r_idle_cnt == c_IDLE_LAST);
  assign w_pick_done = (r_pick_tmr == c_PICK_LAST);

  always_ff @(posedge clock) begin : p_state_reg
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin : p_next_state
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:   w_state_nxt = c_SEEK;
        c_SEEK: begin
          if (here)                     w_state_nxt = c_PICK;
          else if (!w_any && w_idle_hit) w_state_nxt = c_WANDER;
        end
        c_WANDER: if (|sense)      w_state_nxt = c_SEEK;
        c_PICK:   if (w_pick_done) w_state_nxt = c_SEEK;
        default:  w_state_nxt = c_IDLE;
      endcase
    end
  end

  // The idle counter doubles as the wander dwell timer.
  always_comb begin : p_outputs
    w_motor_nxt      = '0;
    w_pick_nxt       = 1'b0;
    w_hist_clr       = 1'b0;
    w_cnt_inc        = 1'b0;
    w_idle_cnt_nxt   = r_idle_cnt;
    w_pick_tmr_nxt   = r_pick_tmr;
    w_wander_dir_nxt = r_wander_dir;
    w_last_dir_nxt   = r_last_dir;
    if (!enable) begin
      w_idle_cnt_nxt = '0;
    end else begin
      case (r_state)
        c_IDLE: w_idle_cnt_nxt = '0;
        c_SEEK: begin
          if (here) begin
            w_pick_tmr_nxt = '0;
            w_idle_cnt_nxt = '0;
          end else if (w_any) begin
            w_motor_nxt    = w_best_oh;
            w_last_dir_nxt = w_best;
            w_idle_cnt_nxt = '0;
          end else if (w_idle_hit) begin
            w_idle_cnt_nxt = '0;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + c_IDLE_W'(1);
          end
        end
        c_WANDER: begin
          if (|sense) begin
            w_motor_nxt    = w_any ? w_best_oh : '0;
            w_last_dir_nxt = w_any ? w_best : r_last_dir;
            w_idle_cnt_nxt = '0;
          end else begin
            w_motor_nxt = w_wander_oh;
            if (w_idle_hit) begin
              w_idle_cnt_nxt   = '0;
              w_wander_dir_nxt = (r_wander_dir == c_LAST_IDX) ? '0 : r_wander_dir + c_DIR_W'(1);
            end else begin
              w_idle_cnt_nxt = r_idle_cnt + c_IDLE_W'(1);
            end
          end
        end
        c_PICK: begin
          if (w_pick_done) begin
            w_pick_nxt     = 1'b1;
            w_cnt_inc      = 1'b1;
            w_hist_clr     = 1'b1;
            w_idle_cnt_nxt = '0;
          end else begin
            w_pick_tmr_nxt = r_pick_tmr + c_PICK_W'(1);
          end
        end
        default: w_idle_cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin : p_datapath
    if (reset) begin
      r_motor      <= '0;
      r_pick       <= 1'b0;
      r_cnt        <= '0;
      r_idle_cnt   <= '0;
      r_pick_tmr   <= '0;
      r_wander_dir <= '0;
      r_last_dir   <= c_LAST_IDX;
      for (int d = 0; d < NUM_DIRS; d++) r_hist[d] <= '0;
    end else begin
      r_motor      <= w_motor_nxt;
      r_pick       <= w_pick_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_pick_tmr   <= w_pick_tmr_nxt;
      r_wander_dir <= w_wander_dir_nxt;
      r_last_dir   <= w_last_dir_nxt;
      if (w_cnt_inc && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
      for (int d = 0; d < NUM_DIRS; d++) begin
        if (w_hist_clr)  r_hist[d] <= '0;
        else if (enable) r_hist[d] <= w_hist_nxt[d];
      end
    end
  end

  assign motor      = r_motor;
  assign pick       = r_pick;
  assign state      = r_state;
  assign pick_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_scoot_bot_ctrl.sv
`default_nettype none
// ============================================================================
// tb_scoot_bot_ctrl : directed scoreboard bench driving two controller
//                     instances (lowest-index ties / 8-bit count, and
//                     rotating ties / 2-bit saturating count) in lockstep.
// Revision 1.0
// ============================================================================
module tb_scoot_bot_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] sense = 4'b0000;
  logic       here = 1'b0;

  logic [3:0] motor_a, motor_b;
  logic       pick_a, pick_b;
  logic [1:0] state_a, state_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [3:0] ma;
    logic [3:0] mb;
    logic       p;
    logic [1:0] st;
    logic [7:0] ca;
    logic [1:0] cb;
  } exp_t;

  exp_t sb_q[$];

  always #5 clock = ~clock;

  scoot_bot_ctrl #(
    .NUM_DIRS(4), .HIST_DEPTH(3), .WANDER_TIMEOUT(8), .PICK_CYCLES(2),
    .TIE_ROTATE(0), .CNT_W(8)
  ) u_dut_a (
    .clock(clock), .reset(reset), .enable(enable), .sense(sense), .here(here),
    .motor(motor_a), .pick(pick_a), .state(state_a), .pick_count(cnt_a)
  );

  scoot_bot_ctrl #(
    .NUM_DIRS(4), .HIST_DEPTH(3), .WANDER_TIMEOUT(8), .PICK_CYCLES(2),
    .TIE_ROTATE(1), .CNT_W(2)
  ) u_dut_b (
    .clock(clock), .reset(reset), .enable(enable), .sense(sense), .here(here),
    .motor(motor_b), .pick(pick_b), .state(state_b), .pick_count(cnt_b)
  );

  // States: 0=IDLE 1=SEEK 2=WANDER 3=PICK
  task automatic step(input string tag, input logic rst, input logic en,
                      input logic [3:0] s, input logic h,
                      input logic [3:0] ma, input logic [3:0] mb, input logic p,
                      input logic [1:0] st, input logic [7:0] ca, input logic [1:0] cb);
    exp_t e;
    exp_t got;
    logic [14:0] obs_a, exp_a;
    logic [8:0]  obs_b, exp_b;
    e.tag = tag; e.ma = ma; e.mb = mb; e.p = p; e.st = st; e.ca = ca; e.cb = cb;
    sb_q.push_back(e);
    reset  = rst;
    enable = en;
    sense  = s;
    here   = h;
    @(posedge clock);
    #1;
    got   = sb_q.pop_front();
    obs_a = {motor_a, pick_a, state_a, cnt_a};
    exp_a = {got.ma, got.p, got.st, got.ca};
    obs_b = {motor_b, pick_b, state_b, cnt_b};
    exp_b = {got.mb, got.p, got.st, got.cb};
    checks++;
    assert (obs_a === exp_a) else begin
      failures++;
      $error("FAIL %s dut_a {motor,pick,state,count} got=%h exp=%h", got.tag, obs_a, exp_a);
    end
    checks++;
    assert (obs_b === exp_b) else begin
      failures++;
      $error("FAIL %s dut_b {motor,pick,state,count} got=%h exp=%h", got.tag, obs_b, exp_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset dominates active sense/here.
    step("reset0", 1, 1, 4'b1111, 1, 4'h0, 4'h0, 0, 2'd0, 8'd0, 2'd0);
    step("reset1", 1, 1, 4'b1111, 1, 4'h0, 4'h0, 0, 2'd0, 8'd0, 2'd0);
    step("idle_to_seek", 0, 1, 4'b0000, 0, 4'h0, 4'h0, 0, 2'd1, 8'd0, 2'd0);

    // A single sense pulse is followed for HIST_DEPTH cycles.
    step("pulse_d1",  0, 1, 4'b0010, 0, 4'b0010, 4'b0010, 0, 2'd1, 8'd0, 2'd0);
    step("hold_d1_a", 0, 1, 4'b0000, 0, 4'b0010, 4'b0010, 0, 2'd1, 8'd0, 2'd0);
    step("hold_d1_b", 0, 1, 4'b0000, 0, 4'b0010, 4'b0010, 0, 2'd1, 8'd0, 2'd0);
    step("drain_d1",  0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd1, 8'd0, 2'd0);

    // Park last_dir at 0 and drain history.
    step("pulse_d0",  0, 1, 4'b0001, 0, 4'b0001, 4'b0001, 0, 2'd1, 8'd0, 2'd0);
    step("hold_d0_a", 0, 1, 4'b0000, 0, 4'b0001, 4'b0001, 0, 2'd1, 8'd0, 2'd0);
    step("hold_d0_b", 0, 1, 4'b0000, 0, 4'b0001, 4'b0001, 0, 2'd1, 8'd0, 2'd0);
    step("drain_d0",  0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 2'd1, 8'd0, 2'd0);

    // Equal scores on dirs 0 and 2: a stays on 0, b alternates.
    step("tie1", 0, 1, 4'b0101, 0, 4'b0001, 4'b0100, 0, 2'd1, 8'd0, 2'd0);
    step("tie2", 0, 1, 4'b0101, 0, 4'b0001, 4'b0001, 0, 2'd1, 8'd0, 2'd0);
    step("tie3", 0, 1, 4'b0101, 0, 4'b0001, 4'b0100, 0, 2'd1, 8'd0, 2'd0);

    // here beats sense; here drops mid-pickup; history is cleared after.
    step("pick_prio", 0, 1, 4'b0101, 1, 4'h0, 4'h0, 0, 2'd3, 8'd0, 2'd0);
    step("pick_hold", 0, 1, 4'b0000, 0, 4'h0, 4'h0, 0, 2'd3, 8'd0, 2'd0);
    step("pick_done", 0, 1, 4'b0000, 0, 4'h0, 4'h0, 1, 2'd1, 8'd1, 2'd1);
    step("hist_clr",  0, 1, 4'b0000, 0, 4'h0, 4'h0, 0, 2'd1, 8'd1, 2'd1);

    // Eight empty SEEK cycles in total (hist_clr was the first) -> WANDER.
    for (int i = 0; i < 6; i++)
      step("seek_empty", 0, 1, 4'b0000, 0, 4'h0, 4'h0, 0, 2'd1, 8'd1, 2'd1);
    step("to_wander", 0, 1, 4'b0000, 0, 4'h0, 4'h0, 0, 2'd2, 8'd1, 2'd1);
    for (int i = 0; i < 8; i++)
      step("wander_d0", 0, 1, 4'b0000, 0, 4'b0001, 4'b0001, 0, 2'd2, 8'd1, 2'd1);
    step("wander_d1",   0, 1, 4'b0000, 0, 4'b0010, 4'b0010, 0, 2'd2, 8'd1, 2'd1);
    step("wander_exit", 0, 1, 4'b1000, 0, 4'b1000, 4'b1000, 0, 2'd1, 8'd1, 2'd1);

    // Disable mid-pickup: no pulse, count unchanged, no stale motor on resume.
    step("abort_enter", 0, 1, 4'b0000, 1, 4'h0, 4'h0, 0, 2'd3, 8'd1, 2'd1);
    step("abort_idle",  0, 0, 4'b0000, 0, 4'h0, 4'h0, 0, 2'd0, 8'd1, 2'd1);
    step("resume",      0, 1, 4'b0000, 0, 4'h0, 4'h0, 0, 2'd1, 8'd1, 2'd1);
    step("resume_seek", 0, 1, 4'b0000, 0, 4'h0, 4'h0, 0, 2'd1, 8'd1, 2'd1);

    // Three more pickups: b's 2-bit count saturates at 3 but still pulses.
    for (int i = 0; i < 3; i++) begin
      step("sat_enter", 0, 1, 4'b0000, 1, 4'h0, 4'h0, 0, 2'd3, 8'(1 + i), 2'((1 + i > 3) ? 3 : 1 + i));
      step("sat_hold",  0, 1, 4'b0000, 0, 4'h0, 4'h0, 0, 2'd3, 8'(1 + i), 2'((1 + i > 3) ? 3 : 1 + i));
      step("sat_done",  0, 1, 4'b0000, 0, 4'h0, 4'h0, 1, 2'd1, 8'(2 + i), 2'((2 + i > 3) ? 3 : 2 + i));
    end
    step("pulse_once", 0, 1, 4'b0000, 0, 4'h0, 4'h0, 0, 2'd1, 8'd4, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
